timer8_apb_slave: RTL and testbench
===================================

Name: timer8_apb_slave

Overview:
- Synthesizable 8-bit timer with an APB-style slave register interface.
- Sits directly downstream of the testbench CPU bus-functional master and consumes its WRITE, READ and WRITE_MASK transactions.
- Decodes four byte registers, inserts programmable wait states, flags illegal accesses with pslverr, and runs a prescaled up/down counter with overflow/underflow flags.

Parameters:
- WAIT_STATES, 1, extra cycles pready stays low after access phase starts (legal 0..3).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- psel  input  1  slave select
- penable  input  1  access phase strobe
- pwrite  input  1  1=write, 0=read
- paddr  input  8  register address
- pwdata  input  8  write data
- prdata  output  8  read data, valid only while pready=1
- pready  output  1  transfer complete, one-cycle pulse
- pslverr  output  1  error response, valid only while pready=1
- tmr_ovf  output  1  mirror of TSR.OVF
- tmr_udf  output  1  mirror of TSR.UDF

Behaviour:
- Reset (async, rst_n=0): all registers 0x00; FSM=IDLE; prdata=0, pready=0, pslverr=0; tmr_ovf=tmr_udf=0; prescaler=0.
- Register map:
  - 0x00 TDR: RW reload value.
  - 0x01 TCR: RW. bit7 LOAD, bit5 DIR (0 up, 1 down), bit4 EN, bits1:0 CKS. Bits 6,3,2 read 0, writes ignored.
  - 0x02 TSR: bit0 OVF, bit1 UDF, other bits read 0. Writing 0 to a flag bit clears it; writing 1 has no effect (safe for read-modify-write).
  - 0x03 TCNT: read-only.
  - Any other address: error.
- APB FSM states IDLE, WAIT, RESP:
  - IDLE -> WAIT when psel&penable=1 and WAIT_STATES>0. IDLE -> RESP when psel&penable=1 and WAIT_STATES=0.
  - WAIT counts WAIT_STATES cycles, then goes to RESP.
  - RESP: pready=1 for exactly one cycle, then IDLE.
  - psel&!penable (setup phase) keeps FSM in IDLE.
  - psel or penable dropping during WAIT: abort to IDLE, no register effect.
- Address, data and pwrite are sampled on entry to RESP. The register write commits on the clock edge that ends RESP.
- Read data is the register value at RESP entry.
- pslverr=1 in RESP for unmapped address or write to TCNT. Error writes change nothing; error reads return prdata=0.
- Outside RESP, prdata=0 and pslverr=0.
- Prescaler:
  - 4-bit counter runs only while EN=1 and LOAD=0; held at 0 otherwise.
  - tick when the low (CKS+1) bits are all 1, giving a period of 2,4,8,16 clk.
- Counter:
  - LOAD=1: TCNT<=TDR every cycle, no counting, no flag set.
  - On tick, up: TCNT+1; at 0xFF wraps to 0x00 and sets OVF.
  - On tick, down: TCNT-1; at 0x00 wraps to 0xFF and sets UDF.
  - Arithmetic is 8-bit modulo.
- Simultaneous hardware flag set and software clear in the same cycle: set wins.
- A write to TCR takes effect on the next cycle's counting.
- tmr_ovf and tmr_udf are registered copies of the flags (same cycle as TSR).
- Reset mid-transfer or mid-count returns everything to reset state immediately. The next transfer is served normally.

Test Plan:
- Reset, then read 0x00..0x03 -> all return 0x00, pslverr=0, pready high exactly 1 cycle, WAIT_STATES+1 cycles after penable.
- Write TDR=0xFD, TCR=0x80 then 0x10 (EN, up, CKS=0) -> TCNT steps FD,FE,FF,00 every 2 clk. OVF=1 and tmr_ovf=1 on the FF->00 wrap. Write TSR=0x00 -> OVF clears.
- TDR=0x01, TCR=0x80 then 0x33 (down, CKS=3) -> TCNT 01,00,FF at 16-clk spacing, UDF set on 00->FF.
- Write 0x55 to 0x03 and read 0x07 -> pslverr=1 on both, TCNT unchanged, prdata=0.
- WRITE_MASK TCR data 0x10 mask 0x10 over 0x23 -> TCR reads 0x33. Reserved-bit write 0xFF -> reads 0xB3.
- Force software TSR clear on the same cycle as a wrap -> OVF remains 1. Assert rst_n low during WAIT -> pready never pulses, registers read 0x00 afterwards.

Source files
------------

// File: rtl/timer8_apb_slave.sv
// timer8_apb_slave: 8-bit prescaled up/down timer
// behind an APB-style register slave with wait states.
module timer8_apb_slave #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       tmr_ovf,
  output logic       tmr_udf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] WS_LAST =
    (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);
  localparam logic [7:0] TCR_MASK = 8'hB3;

  state_t     state;
  state_t     state_n;
  logic [1:0] wcnt;
  logic       access;
  logic       enter_resp;

  logic       hit_tdr;
  logic       hit_tcr;
  logic       hit_tsr;
  logic       hit_tcnt;
  logic       a_err;
  logic [7:0] a_rd;

  logic       w_q;
  logic       err_q;
  logic [1:0] a_q;
  logic [7:0] wd_q;
  logic [7:0] rd_q;

  logic       commit;
  logic       wr_tdr;
  logic       wr_tcr;
  logic       wr_tsr;

  logic [7:0] tdr;
  logic [7:0] tcr;
  logic [7:0] tcnt;
  logic       ovf;
  logic       udf;
  logic [3:0] presc;
  logic       run;
  logic       tap;
  logic       tick;
  logic       ovf_set;
  logic       udf_set;

  assign access = psel & penable;

  // APB state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // APB next-state: wait states, abort on dropped strobe
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (access)
          state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!access)
          state_n = S_IDLE;
        else if (wcnt == WS_LAST)
          state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // APB outputs are only non-zero during the response cycle
  always_comb begin
    pready  = 1'b0;
    prdata  = 8'h00;
    pslverr = 1'b0;
    if (state == S_RESP) begin
      pready  = 1'b1;
      prdata  = rd_q;
      pslverr = err_q;
    end
  end

  // Wait-state cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wcnt <= 2'd0;
    else if (state == S_WAIT)  wcnt <= wcnt + 2'd1;
    else                       wcnt <= 2'd0;
  end

  assign hit_tdr  = (paddr == 8'h00);
  assign hit_tcr  = (paddr == 8'h01);
  assign hit_tsr  = (paddr == 8'h02);
  assign hit_tcnt = (paddr == 8'h03);
  assign a_err    = ~(hit_tdr | hit_tcr | hit_tsr | hit_tcnt)
                  | (pwrite & hit_tcnt);

  // Register read mux
  always_comb begin
    a_rd = 8'h00;
    unique case (1'b1)
      hit_tdr:  a_rd = tdr;
      hit_tcr:  a_rd = tcr;
      hit_tsr:  a_rd = {6'b0, udf, ovf};
      hit_tcnt: a_rd = tcnt;
      default:  a_rd = 8'h00;
    endcase
  end

  assign enter_resp = (state != S_RESP)
                    & (state_n == S_RESP);

  // Capture the transfer as it enters the response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= 1'b0;
      err_q <= 1'b0;
      a_q   <= 2'd0;
      wd_q  <= 8'h00;
      rd_q  <= 8'h00;
    end else if (enter_resp) begin
      w_q   <= pwrite;
      err_q <= a_err;
      a_q   <= paddr[1:0];
      wd_q  <= pwdata;
      rd_q  <= (pwrite | a_err) ? 8'h00 : a_rd;
    end
  end

  assign commit = (state == S_RESP) & w_q & ~err_q;
  assign wr_tdr = commit & (a_q == 2'd0);
  assign wr_tcr = commit & (a_q == 2'd1);
  assign wr_tsr = commit & (a_q == 2'd2);

  assign run = tcr[4] & ~tcr[7];

  // Prescaler tap selected by CKS
  always_comb begin
    tap = 1'b0;
    unique case (tcr[1:0])
      2'd0:    tap = presc[0];
      2'd1:    tap = &presc[1:0];
      2'd2:    tap = &presc[2:0];
      default: tap = &presc;
    endcase
  end

  assign tick    = run & tap;
  assign ovf_set = tick & ~tcr[5] & (tcnt == 8'hFF);
  assign udf_set = tick &  tcr[5] & (tcnt == 8'h00);

  // Prescaler free-runs only while counting is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   presc <= 4'd0;
    else if (run) presc <= presc + 4'd1;
    else          presc <= 4'd0;
  end

  // Counter: reload while LOAD, else step on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt <= 8'h00;
    else if (tcr[7])
      tcnt <= tdr;
    else if (tick)
      tcnt <= tcr[5] ? tcnt - 8'd1 : tcnt + 8'd1;
  end

  // Software registers; a hardware flag set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr <= 8'h00;
      tcr <= 8'h00;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_tdr) tdr <= wd_q;
      if (wr_tcr) tcr <= wd_q & TCR_MASK;
      ovf <= ovf_set | (ovf & ~(wr_tsr & ~wd_q[0]));
      udf <= udf_set | (udf & ~(wr_tsr & ~wd_q[1]));
    end
  end

  assign tmr_ovf = ovf;
  assign tmr_udf = udf;

endmodule

// File: tb/tb_timer8_apb_slave.sv
// tb_timer8_apb_slave: random + directed APB traffic,
// scoreboard against a cycle-level timer model.
module tb_timer8_apb_slave;

  localparam int WS = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       tmr_ovf;
  logic       tmr_udf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer8_apb_slave #(.WAIT_STATES(WS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf)
  );

  typedef struct {
    bit         rd;
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t sb [1024];
  int   wp = 0;
  int   rp = 0;

  logic [7:0] m_tdr = 8'h00;
  logic [7:0] m_tcr = 8'h00;
  logic [7:0] m_tcnt = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  int         m_r = 0;

  int         wr_seq = 0;
  int         done_seq = 0;
  logic [1:0] pend_a = 2'd0;
  logic [7:0] pend_d = 8'h00;

  bit done = 1'b0;
  bit reported = 1'b0;

  // Reference model: ticks every 2<<CKS running cycles
  initial begin
    bit run;
    bit tick;
    bit so;
    bit su;
    int per;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_tdr = 8'h00;
        m_tcr = 8'h00;
        m_tcnt = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_r = 0;
        done_seq = wr_seq;
      end else begin
        run  = m_tcr[4] && !m_tcr[7];
        per  = 2 << m_tcr[1:0];
        tick = run && ((m_r % per) == per - 1);
        m_r  = run ? m_r + 1 : 0;
        so = 1'b0;
        su = 1'b0;
        if (m_tcr[7]) begin
          m_tcnt = m_tdr;
        end else if (tick) begin
          if (m_tcr[5]) begin
            su = (m_tcnt == 8'h00);
            m_tcnt = m_tcnt - 8'd1;
          end else begin
            so = (m_tcnt == 8'hFF);
            m_tcnt = m_tcnt + 8'd1;
          end
        end
        if (wr_seq != done_seq) begin
          case (pend_a)
            2'd0: m_tdr = pend_d;
            2'd1: m_tcr = pend_d & 8'hB3;
            2'd2: begin
              if (!pend_d[0]) m_ovf = 1'b0;
              if (!pend_d[1]) m_udf = 1'b0;
            end
            default: ;
          endcase
          done_seq = wr_seq;
        end
        if (so) m_ovf = 1'b1;
        if (su) m_udf = 1'b1;
      end
    end
  end

  function automatic logic [7:0] mread(
    input logic [1:0] a
  );
    case (a)
      2'd0:    return m_tdr;
      2'd1:    return m_tcr;
      2'd2:    return {6'b0, m_udf, m_ovf};
      default: return m_tcnt;
    endcase
  endfunction

  task automatic chk(
    input bit    ok,
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on pready, checks flags
  initial begin
    int   acc;
    bit   prev;
    exp_t e;
    acc = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = 0;
        prev = 1'b0;
        continue;
      end
      chk(tmr_ovf == m_ovf, "tmr_ovf", tmr_ovf, m_ovf);
      chk(tmr_udf == m_udf, "tmr_udf", tmr_udf, m_udf);
      if (prev)
        chk(!pready, "pready_width", pready, 0);
      if (pready) begin
        chk(acc == WS + 1, "latency", acc, WS + 1);
        chk(wp > rp, "pready_expected", wp - rp, 1);
        if (wp > rp) begin
          e = sb[rp % 1024];
          rp++;
          chk(pslverr == e.err, "pslverr",
              pslverr, e.err);
          if (e.rd)
            chk(prdata == e.data, "prdata",
                prdata, e.data);
        end
        acc = 0;
      end else begin
        chk(prdata == 8'h00 && pslverr == 1'b0,
            "idle_outputs", {pslverr, prdata}, 0);
        if (psel && penable) begin
          acc++;
          chk(acc <= WS + 1, "access_len", acc, WS + 1);
        end else begin
          acc = 0;
        end
      end
      prev = pready;
      if (done && !reported) begin
        chk(rp == wp, "sb_drained", wp - rp, 0);
        reported = 1'b1;
      end
    end
  end

  task automatic xfer(
    input  bit         wr,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] rd
  );
    exp_t e;
    bit   err;
    int   n;
    @(posedge clk); #1;
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (WS) begin
      @(posedge clk); #1;
    end
    err = (a > 8'd3) || (wr && a == 8'd3);
    e.rd = !wr;
    e.err = err;
    e.data = err ? 8'h00 : mread(a[1:0]);
    sb[wp % 1024] = e;
    wp++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready && n < WS + 20);
    rd = prdata;
    if (pready && wr && !err) begin
      pend_a = a[1:0];
      pend_d = d;
      wr_seq++;
    end
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] x;
    xfer(1'b1, a, d, x);
  endtask

  task automatic rd(input logic [7:0] a);
    logic [7:0] x;
    xfer(1'b0, a, 8'h00, x);
  endtask

  task automatic wmask(
    input logic [7:0] a,
    input logic [7:0] d,
    input logic [7:0] m
  );
    logic [7:0] cur;
    xfer(1'b0, a, 8'h00, cur);
    wr(a, (cur & ~m) | (d & m));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) rd(8'(i));

    wr(8'h00, 8'hFD);
    wr(8'h01, 8'h80);
    wr(8'h01, 8'h10);
    repeat (4) rd(8'h03);
    for (int i = 0; i < 64 && !m_ovf; i++) begin
      @(posedge clk); #1;
    end
    rd(8'h02);
    wr(8'h02, 8'h00);
    rd(8'h02);

    wr(8'h00, 8'h01);
    wr(8'h01, 8'h80);
    wr(8'h01, 8'h33);
    for (int i = 0; i < 8; i++) begin
      rd(8'h03);
      repeat (5) @(posedge clk);
    end
    rd(8'h02);

    wr(8'h03, 8'h55);
    rd(8'h07);
    rd(8'h03);
    wr(8'h09, 8'hAA);
    rd(8'hFF);

    wr(8'h02, 8'h00);
    wr(8'h01, 8'h23);
    wmask(8'h01, 8'h10, 8'h10);
    rd(8'h01);
    wr(8'h01, 8'hFF);
    rd(8'h01);
    rd(8'h03);

    wr(8'h02, 8'h00);
    wr(8'h00, 8'hFF);
    wr(8'h01, 8'h80);
    wr(8'h01, 8'h13);
    for (int i = 0; i < 40; i++) begin
      if ((m_r + 3 + WS) % 16 == 15) break;
      @(posedge clk); #1;
    end
    wr(8'h02, 8'h00);
    rd(8'h02);
    rd(8'h03);

    wr(8'h00, 8'hA5);
    wr(8'h01, 8'h23);
    @(posedge clk); #1;
    psel = 1'b1;
    pwrite = 1'b1;
    paddr = 8'h00;
    pwdata = 8'h11;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd(8'(i));

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 4) == 0)
        a = 8'($urandom_range(4, 255));
      else
        a = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        wr(a, 8'($urandom));
      else
        rd(a);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
